// File: rtl/mux_serial_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_serial_sequencer_if : word handshake, mux8x1 bus and serial stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface mux_serial_sequencer_if;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mux_d;
  logic [2:0] mux_s;
  logic       mux_y;
  logic       ser_bit;
  logic       ser_valid;
  logic       ser_first;
  logic       ser_last;
  logic       busy;

  // master is the surrounding environment (word source, mux8x1, stream sink)
  modport master (
    output flush, in_data, in_valid, mux_y,
    input  in_ready, mux_d, mux_s, ser_bit, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  flush, in_data, in_valid, mux_y,
    output in_ready, mux_d, mux_s, ser_bit, ser_valid, ser_first, ser_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_serial_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_serial_sequencer : steps mux8x1 select over a held word, emits framed bits
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_serial_sequencer #(
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_serial_sequencer_if.slave bus
);
  localparam int               DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       START    = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       mux_d;
  logic [2:0]       mux_s;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;

  logic term;
  logic word_done;
  logic accept;

  assign term      = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign word_done = term && (bit_cnt == 3'd7);
  // Ready on the final bit's edge lets the next word start with no idle cycle
  assign bus.in_ready = !bus.flush && ((state == IDLE) || word_done);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      div_cnt   <= '0;
      mux_d     <= 8'd0;
      mux_s     <= START;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      if (bus.flush) begin
        state   <= IDLE;
        mux_s   <= START;
        bit_cnt <= 3'd0;
        div_cnt <= '0;
      end else begin
        if (term) begin
          ser_bit   <= bus.mux_y;
          ser_valid <= 1'b1;
          ser_first <= (bit_cnt == 3'd0);
          ser_last  <= (bit_cnt == 3'd7);
          div_cnt   <= '0;
          if (bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 3'd1;
            mux_s   <= MSB_FIRST ? (mux_s - 3'd1) : (mux_s + 3'd1);
          end else begin
            state <= IDLE;
            mux_s <= START;
          end
        end else if (state == SHIFT) begin
          div_cnt <= div_cnt + 1'b1;
        end
        // Accept overrides the end-of-word return to IDLE
        if (accept) begin
          mux_d   <= bus.in_data;
          mux_s   <= START;
          bit_cnt <= 3'd0;
          div_cnt <= '0;
          state   <= SHIFT;
        end
      end
    end
  end

  assign bus.mux_d     = mux_d;
  assign bus.mux_s     = mux_s;
  assign bus.ser_bit   = ser_bit;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_first = ser_first;
  assign bus.ser_last  = ser_last;
  assign bus.busy      = (state == SHIFT);
endmodule
`default_nettype wire

// File: tb/tb_mux_serial_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_serial_sequencer : four parameter sets driven in lockstep vs a word-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux_serial_sequencer;
  localparam int          NCFG   = 4;
  localparam logic [15:0] BCS    = {4'd3, 4'd4, 4'd1, 4'd1};
  localparam logic [3:0]  MSBS   = 4'b1010;
  localparam int          NCYC   = 1600;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic [7:0] in_data;

  logic [NCFG-1:0] rdy, sv, sb, sf, sl, bsy;
  logic [7:0]      md [NCFG];
  logic [2:0]      ms [NCFG];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NCFG; i++) begin : g_dut
    mux_serial_sequencer_if bus ();
    assign bus.flush    = flush;
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;
    assign bus.mux_y    = bus.mux_d[bus.mux_s];
    assign rdy[i] = bus.in_ready;
    assign sv[i]  = bus.ser_valid;
    assign sb[i]  = bus.ser_bit;
    assign sf[i]  = bus.ser_first;
    assign sl[i]  = bus.ser_last;
    assign bsy[i] = bus.busy;
    assign md[i]  = bus.mux_d;
    assign ms[i]  = bus.mux_s;
    mux_serial_sequencer #(
      .BIT_CYCLES(int'(BCS[i*4 +: 4])),
      .MSB_FIRST (MSBS[i])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Word-level model: k counts edges since the word was accepted
  bit         active [NCFG];
  logic [7:0] word   [NCFG];
  int         k      [NCFG];
  bit         e_v    [NCFG];
  bit         e_bit  [NCFG];
  bit         e_f    [NCFG];
  bit         e_l    [NCFG];
  bit         acc    [NCFG];

  function automatic int bc_of(int c);
    return int'(BCS[c*4 +: 4]);
  endfunction

  function automatic int pos_of(int c, int j);
    return MSBS[c] ? 7 - j : j;
  endfunction

  function automatic logic [2:0] start_of(int c);
    return MSBS[c] ? 3'd7 : 3'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      active[c] = 1'b0; word[c] = 8'd0; k[c] = 0;
      e_v[c] = 1'b0; e_bit[c] = 1'b0; e_f[c] = 1'b0; e_l[c] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCFG; c++) begin
      logic [2:0] es;
      es = active[c] ? 3'(pos_of(c, k[c] / bc_of(c))) : start_of(c);
      check_eq($sformatf("c%0d busy", c), 32'(bsy[c]), 32'(active[c]));
      check_eq($sformatf("c%0d mux_s", c), 32'(ms[c]), 32'(es));
      check_eq($sformatf("c%0d mux_d", c), 32'(md[c]), 32'(word[c]));
      check_eq($sformatf("c%0d ser_valid", c), 32'(sv[c]), 32'(e_v[c]));
      check_eq($sformatf("c%0d ser_first", c), 32'(sf[c]), 32'(e_f[c]));
      check_eq($sformatf("c%0d ser_last", c), 32'(sl[c]), 32'(e_l[c]));
      if (e_v[c]) check_eq($sformatf("c%0d ser_bit", c), 32'(sb[c]), 32'(e_bit[c]));
    end
  endtask

  task automatic check_reset_values(input string when);
    for (int c = 0; c < NCFG; c++) begin
      check_eq($sformatf("c%0d %s busy", c, when), 32'(bsy[c]), 32'd0);
      check_eq($sformatf("c%0d %s mux_s", c, when), 32'(ms[c]), 32'(start_of(c)));
      check_eq($sformatf("c%0d %s mux_d", c, when), 32'(md[c]), 32'd0);
      check_eq($sformatf("c%0d %s ser_v/b/f/l", c, when),
               32'({sv[c], sb[c], sf[c], sl[c]}), 32'd0);
    end
  endtask

  logic [7:0] tab [7];
  int n_sent;

  initial begin
    tab = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h3C, 8'hC3};
    n_sent   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < NCFG; c++)
      check_eq($sformatf("c%0d in_ready after reset", c), 32'(rdy[c]), 32'd1);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      flush    = (cyc > 120) && ($urandom_range(0, 99) < 3);
      in_valid = ($urandom_range(0, 9) < (((cyc % 300) < 200) ? 10 : 3));
      in_data  = (n_sent < 7) ? tab[n_sent] : 8'($urandom);
      #1;
      for (int c = 0; c < NCFG; c++) begin
        bit er;
        er = !flush && (!active[c] || k[c] == 8 * bc_of(c) - 1);
        check_eq($sformatf("c%0d in_ready", c), 32'(rdy[c]), 32'(er));
        acc[c] = in_valid && er;
      end
      if (acc[0]) n_sent++;
      @(posedge clk);
      for (int c = 0; c < NCFG; c++) begin
        e_v[c] = 1'b0; e_f[c] = 1'b0; e_l[c] = 1'b0;
        if (flush) begin
          active[c] = 1'b0;
          k[c]      = 0;
        end else begin
          if (active[c]) begin
            k[c]++;
            if (k[c] % bc_of(c) == 0) begin
              int j;
              j = k[c] / bc_of(c) - 1;
              e_v[c]   = 1'b1;
              e_bit[c] = word[c][pos_of(c, j)];
              e_f[c]   = (j == 0);
              e_l[c]   = (j == 7);
            end
            if (k[c] == 8 * bc_of(c)) active[c] = 1'b0;
          end
          if (acc[c]) begin
            active[c] = 1'b1;
            word[c]   = in_data;
            k[c]      = 0;
          end
        end
      end

      // Asynchronous reset in the middle of a word, checked before any clock edge
      if (cyc == 700) begin
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
